// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the request side (core -> LSU) and the data-memory side
// (LSU -> memory) of the load/store unit into one interface.
//
// Signals
//   start, mem_write, funct3[2:0], addr[31:0], wdata[31:0] : request in
//   busy, done, rdata[31:0], misaligned, bus_err           : status/result out
//   dm_req, dm_we, dm_addr[31:0], dm_be[3:0], dm_wdata[31:0] : memory request
//   dm_ack, dm_rdata[31:0]                                 : memory response
//
// Modports
//   slave  : the load/store unit itself
//   master : the environment (core issuing requests plus data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        start;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport slave (
    input  start, mem_write, funct3, addr, wdata, dm_ack, dm_rdata,
    output busy, done, rdata, misaligned, bus_err,
           dm_req, dm_we, dm_addr, dm_be, dm_wdata
  );

  modport master (
    output start, mem_write, funct3, addr, wdata, dm_ack, dm_rdata,
    input  busy, done, rdata, misaligned, bus_err,
           dm_req, dm_we, dm_addr, dm_be, dm_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit. Accepts one byte/halfword/word access at a time,
// checks alignment, drives a single-beat request to data memory with byte
// enables and lane-replicated store data, then formats load data
// (sign/zero extension) into rdata.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : load_store_unit_if.slave (request, status and data-memory signals)
//
// Optional feature
//   LSU_TIMEOUT_EN : when defined, a REQ phase that sees no dm_ack for 255
//                    cycles is abandoned and completes with bus_err=1.
//                    When undefined, REQ waits forever and bus_err is 0.
//
// Timing: done is high 2 cycles after start when dm_ack arrives in the first
// REQ cycle, and 1 cycle after start on an alignment fault.
// ---------------------------------------------------------------------------
module load_store_unit (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic [31:0] rdata_reg;
  logic        misaligned_reg;
  logic        dm_req_reg;
  logic        dm_we_reg;
  logic [31:0] dm_addr_reg;
  logic [3:0]  dm_be_reg;
  logic [31:0] dm_wdata_reg;

  logic        fault_w;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] lane_shift;
  logic [31:0] load_w;
  logic        timeout_w;

  // Alignment check on the incoming request; funct3[1:0]=11 is not a
  // valid RV32I access size and is reported the same way.
  always_comb begin
    fault_w = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   fault_w = bus.addr[0];
      2'b10:   fault_w = (bus.addr[1:0] != 2'b00);
      2'b11:   fault_w = 1'b1;
      default: fault_w = 1'b0;
    endcase
  end

  always_comb begin
    be_w = 4'b1111;
    case (bus.funct3[1:0])
      2'b00:   be_w = 4'b0001 << bus.addr[1:0];
      2'b01:   be_w = 4'b0011 << bus.addr[1:0];
      default: be_w = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick
  // the destination bytes; memory never has to shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_w[gi*8 +: 8] =
        (bus.funct3[1:0] == 2'b00) ? bus.wdata[7:0] :
        (bus.funct3[1:0] == 2'b01) ? bus.wdata[(gi%2)*8 +: 8] :
                                     bus.wdata[gi*8 +: 8];
    end
  endgenerate

  // Bring the addressed byte/halfword down to bit 0. Halfwords are always
  // at offset 0 or 2 here, so the same byte shift serves both sizes.
  assign lane_shift = bus.dm_rdata >> {offset_reg, 3'b000};

  always_comb begin
    load_w = bus.dm_rdata;
    case (funct3_reg[1:0])
      2'b00:   load_w = {{24{~funct3_reg[2] & lane_shift[7]}},  lane_shift[7:0]};
      2'b01:   load_w = {{16{~funct3_reg[2] & lane_shift[15]}}, lane_shift[15:0]};
      default: load_w = bus.dm_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;
  logic       bus_err_reg;

  // The counter is 0 in the first REQ cycle; reaching 254 without an ack
  // means this is the 255th REQ cycle, after which the access is dropped.
  assign timeout_w = (tmo_cnt_reg == 8'd254);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_reg <= 8'd0;
      bus_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            tmo_cnt_reg <= 8'd0;
            bus_err_reg <= 1'b0;
          end
        end
        REQ: begin
          if (!bus.dm_ack) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            if (timeout_w) bus_err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_err = bus_err_reg;
`else
  assign timeout_w   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      offset_reg     <= 2'b00;
      rdata_reg      <= 32'd0;
      misaligned_reg <= 1'b0;
      dm_req_reg     <= 1'b0;
      dm_we_reg      <= 1'b0;
      dm_addr_reg    <= 32'd0;
      dm_be_reg      <= 4'b0000;
      dm_wdata_reg   <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            we_reg         <= bus.mem_write;
            funct3_reg     <= bus.funct3;
            offset_reg     <= bus.addr[1:0];
            misaligned_reg <= fault_w;
            if (fault_w) begin
              state_reg <= DONE;
            end else begin
              state_reg    <= REQ;
              dm_req_reg   <= 1'b1;
              dm_we_reg    <= bus.mem_write;
              dm_addr_reg  <= {bus.addr[31:2], 2'b00};
              dm_be_reg    <= be_w;
              dm_wdata_reg <= wdata_w;
            end
          end
        end
        REQ: begin
          if (bus.dm_ack) begin
            dm_req_reg <= 1'b0;
            state_reg  <= DONE;
            if (!we_reg) rdata_reg <= load_w;
          end else if (timeout_w) begin
            dm_req_reg <= 1'b0;
            state_reg  <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.rdata      = rdata_reg;
  assign bus.misaligned = misaligned_reg;
  assign bus.dm_req     = dm_req_reg;
  assign bus.dm_we      = dm_we_reg;
  assign bus.dm_addr    = dm_addr_reg;
  assign bus.dm_be      = dm_be_reg;
  assign bus.dm_wdata   = dm_wdata_reg;

endmodule
